// File: rtl/logic_op_sequencer.sv
// Purpose : bit-serial sequencer sharing one 1-bit gate bank (NOT a/b, OR, AND, XOR, XNOR) over WIDTH-bit operands.
// Latency : result valid WIDTH+1 cycles after the accept cycle (1 cycle for illegal opcodes 6/7).
// Backpr. : in_ready only in IDLE; result/err held in DONE until out_ready. Option: RESULT_PARITY_EN adds out_parity.
module logic_op_sequencer #(
    parameter int WIDTH = 8,
    parameter int IDXW  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_err,
`ifdef RESULT_PARITY_EN
    output logic             out_parity,
`endif
    output logic             busy,
    output logic [IDXW-1:0]  bit_idx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_lat;
    logic [WIDTH-1:0] b_lat;
    logic [2:0]       op_lat;
    logic [WIDTH-1:0] result_q;
    logic             err_q;
    logic [IDXW-1:0]  idx_q;
    logic [WIDTH-1:0] result_next;
    logic             gate_bit;
    logic             accept;
    logic             op_legal;
    logic             last_bit;
`ifdef RESULT_PARITY_EN
    logic             parity_q;
`endif

    assign accept    = in_valid && in_ready;
    assign op_legal  = (in_op <= 3'd5);
    assign last_bit  = (idx_q == LAST_IDX);

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign out_result = result_q;
    assign out_err    = err_q;
    assign bit_idx    = idx_q;
`ifdef RESULT_PARITY_EN
    assign out_parity = parity_q;
`endif

    // Shared 1-bit gate bank on the latched operand bits, plus the result word with that bit merged in
    always_comb begin
        gate_bit = 1'b0;
        case (op_lat)
            3'd0:    gate_bit = ~a_lat[idx_q];
            3'd1:    gate_bit = ~b_lat[idx_q];
            3'd2:    gate_bit = a_lat[idx_q] | b_lat[idx_q];
            3'd3:    gate_bit = a_lat[idx_q] & b_lat[idx_q];
            3'd4:    gate_bit = a_lat[idx_q] ^ b_lat[idx_q];
            3'd5:    gate_bit = ~(a_lat[idx_q] ^ b_lat[idx_q]);
            default: gate_bit = 1'b0;
        endcase
        result_next         = result_q;
        result_next[idx_q]  = gate_bit;
    end

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state: illegal opcodes skip RUN and report straight from DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = op_legal ? RUN : DONE;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: latch command on accept, fill one result bit per clock, clear err on handoff
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_lat    <= '0;
            b_lat    <= '0;
            op_lat   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            idx_q    <= '0;
`ifdef RESULT_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_lat    <= in_a;
                        b_lat    <= in_b;
                        op_lat   <= in_op;
                        result_q <= '0;
                        err_q    <= !op_legal;
                        idx_q    <= '0;
`ifdef RESULT_PARITY_EN
                        parity_q <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    result_q <= result_next;
                    if (last_bit) begin
                        idx_q    <= '0;
`ifdef RESULT_PARITY_EN
                        parity_q <= ^result_next;
`endif
                    end else begin
                        idx_q <= idx_q + IDXW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) err_q <= 1'b0;
                end
                default: begin
                    idx_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Purpose : random + directed bench for logic_op_sequencer against a word-level reference model.
// Latency : expects out_valid WIDTH+1 cycles after accept (1 for opcodes 6/7); bounded waits.
// Backpr. : exercises out_ready stalls and commands offered while busy. RESULT_PARITY_EN adds parity checks.
module tb_logic_op_sequencer;

    localparam int W  = 8;
    localparam int IW = 3;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic          out_err;
`ifdef RESULT_PARITY_EN
    logic          out_parity;
`endif
    logic          busy;
    logic [IW-1:0] bit_idx;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] vec_exp [6];

    logic_op_sequencer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_err    (out_err),
`ifdef RESULT_PARITY_EN
        .out_parity (out_parity),
`endif
        .busy       (busy),
        .bit_idx    (bit_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time guard so the run always ends
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Word-level reference: the whole operation at once, no bit walking
    function automatic logic [W-1:0] model_result(input logic [2:0] op,
                                                  input logic [W-1:0] a,
                                                  input logic [W-1:0] b);
        case (op)
            3'd0:    return ~a;
            3'd1:    return ~b;
            3'd2:    return a | b;
            3'd3:    return a & b;
            3'd4:    return a ^ b;
            3'd5:    return ~(a ^ b);
            default: return '0;
        endcase
    endfunction

    task automatic check_idle_outputs(input string tag, input logic [W-1:0] exp_res);
        chk({tag, "_in_ready"},  in_ready,  1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_bit_idx"},   bit_idx,   0);
        chk({tag, "_out_err"},   out_err,   0);
        chk({tag, "_result"},    out_result, exp_res);
    endtask

    // One full command: offer, accept, walk, optional stall, handoff
    task automatic run_cmd(input logic [2:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input int hold);
        logic [W-1:0] exp_res;
        logic         exp_err;
        int           lat;
        exp_err = (op > 3'd5);
        exp_res = model_result(op, a, b);
        @(negedge clk);
        chk("offer_in_ready", in_ready, 1);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        // keep offering junk commands: none may be taken while busy
        in_op = 3'($urandom);
        in_a  = W'($urandom);
        in_b  = W'($urandom);
        lat = 1;
        while (!out_valid && lat < 4 * W) begin
            chk("run_bit_idx",  bit_idx, lat - 1);
            chk("run_busy",     busy, 1);
            chk("run_in_ready", in_ready, 0);
            in_a = W'($urandom);
            in_b = W'($urandom);
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, exp_err ? 1 : W + 1);
        for (int i = 0; i < hold; i++) begin
            chk("stall_valid",    out_valid, 1);
            chk("stall_result",   out_result, exp_res);
            chk("stall_in_ready", in_ready, 0);
            @(negedge clk);
        end
        chk("done_busy",   busy, 1);
        chk("done_result", out_result, exp_res);
        chk("done_err",    out_err, exp_err);
`ifdef RESULT_PARITY_EN
        chk("done_parity", out_parity, ^exp_res);
`endif
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_idle_outputs("handoff", exp_res);
    endtask

    initial begin
        vec_exp[0] = 8'h5A;
        vec_exp[1] = 8'hC3;
        vec_exp[2] = 8'hBD;
        vec_exp[3] = 8'h24;
        vec_exp[4] = 8'h99;
        vec_exp[5] = 8'h66;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset", '0);

        // Reference vectors a=0xA5 b=0x3C through every legal op
        for (int op = 0; op < 6; op++) begin
            run_cmd(3'(op), 8'hA5, 8'h3C, 0);
            chk("vec_result", out_result, vec_exp[op]);
        end

        // Backpressure: consumer stalls for 5 cycles
        run_cmd(3'd4, 8'hFF, 8'h0F, 5);
        chk("bp_result", out_result, 8'hF0);

        // Illegal opcode reports in one cycle with zero result
        run_cmd(3'd7, 8'h12, 8'h34, 0);
        chk("illegal_result", out_result, 8'h00);
        run_cmd(3'd6, 8'hFF, 8'hFF, 2);

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 3'd3;
        in_a     = 8'hFF;
        in_b     = 8'hFF;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 4 * W && bit_idx != 3'd4; i++) @(negedge clk);
        chk("midrst_reached_idx4", bit_idx, 4);
        chk("midrst_partial_nonzero", (out_result != 0), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst", '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_cmd(3'd2, 8'h01, 8'h80, 0);
        chk("postrst_result", out_result, 8'h81);

`ifdef RESULT_PARITY_EN
        run_cmd(3'd4, 8'hA5, 8'h01, 0);
        chk("par_xor_result", out_result, 8'hA4);
        chk("par_xor_parity", out_parity, 1);
        run_cmd(3'd2, 8'hA5, 8'h3C, 0);
        chk("par_or_result", out_result, 8'hBD);
        chk("par_or_parity", out_parity, 0);
`endif

        // Random commands, including illegal opcodes and random stalls
        for (int n = 0; n < 40; n++) begin
            run_cmd(3'($urandom_range(0, 7)), W'($urandom), W'($urandom),
                    int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/logic_op_sequencer.md
Name: logic_op_sequencer

Overview:
- Bit-serial controller that time-shares one 1-bit gate bank (NOT a, NOT b, OR, AND, XOR, XNOR) across WIDTH-bit operands.
- Accepts a command (opcode plus two operands) over a valid/ready handshake.
- Walks the operands LSB-first, one bit per clock, into a result register.
- Presents the result over a second valid/ready handshake. Sits between a command source and the shared logic-gate datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.
- IDXW, $clog2(WIDTH) (minimum 1), width of the bit_idx counter; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset.
- in_valid  input  1  command valid.
- in_ready  output  1  command accepted when in_valid && in_ready.
- in_op  input  3  opcode: 0 NOT a, 1 NOT b, 2 OR, 3 AND, 4 XOR, 5 XNOR, 6/7 illegal.
- in_a  input  WIDTH  operand a.
- in_b  input  WIDTH  operand b.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes result when out_valid && out_ready.
- out_result  output  WIDTH  result word.
- out_err  output  1  illegal opcode flag; qualified by out_valid.
- busy  output  1  high in RUN or DONE.
- bit_idx  output  IDXW  bit currently processed in RUN; 0 otherwise.

Interface note: one clock; reset is asynchronous and active-low. The clock is named clk and the reset is named rst_n.

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_result=0, out_err=0, busy=0, bit_idx=0, latched operands/op=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On accept with legal op: latch in_a, in_b, in_op; clear result; bit_idx=0; go to RUN.
  - On accept with op 6/7: result=0, err=1; go to DONE directly (out_valid on the next cycle).
- RUN:
  - in_ready=0.
  - Each edge writes result[bit_idx] = gate(op, a_lat[bit_idx], b_lat[bit_idx]), then increments bit_idx.
  - On the edge where bit_idx==WIDTH-1, write the last bit, clear bit_idx to 0, go to DONE.
  - Latency: out_valid rises WIDTH+1 edges after the accepting edge. For WIDTH=1, RUN lasts exactly one cycle.
- DONE:
  - out_valid=1. out_result and out_err are held stable until out_ready.
  - On out_valid && out_ready: go to IDLE and clear out_valid and out_err. out_result holds its last value.
  - in_ready=0 in DONE, so there is no accept in the same cycle as a handoff. Minimum spacing between commands is one IDLE cycle.
- Operand/opcode inputs are ignored outside the IDLE accept cycle. Changing them during RUN has no effect.
- out_ready is ignored when out_valid=0.
- in_valid deasserted without acceptance is legal; there is no command memory.
- Reset asserted mid-RUN or mid-DONE aborts the operation immediately (asynchronously) to reset values; the partial result is discarded.
- Gate bank is purely combinational on latched bits; no arithmetic, no carries.
- bit_idx never exceeds WIDTH-1 (no wrap past WIDTH).

Optional Feature:
- Macro RESULT_PARITY_EN.
- When defined: extra output port out_parity (1 bit) = XOR-reduction of out_result. It is registered together with the final bit, valid whenever out_valid=1, 0 at reset and for illegal ops.
- When undefined: port absent, no parity logic.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release -> in_ready=1, out_valid=0, busy=0, bit_idx=0, out_result=0x00.
- WIDTH=8, a=0xA5, b=0x3C, ops 0..5 in sequence, out_ready=1 -> results 0x5A, 0xC3, 0xBD, 0x24, 0x99, 0x66, out_err=0. Each out_valid appears 9 edges after accept; bit_idx counts 0..7 during RUN.
- Backpressure: op=4, a=0xFF, b=0x0F, out_ready=0 for 5 cycles after out_valid -> out_result=0xF0 held stable, in_ready=0 throughout. In_valid with a new command during RUN/DONE is not accepted.
- Illegal opcode: op=7, a=0x12, b=0x34 -> out_valid one cycle after accept, out_result=0x00, out_err=1; cleared after handshake.
- Reset mid-operation: accept op=3, assert rst_n low after bit_idx=4 -> all outputs return to reset values in the same cycle. After release, a new command op=2, a=0x01, b=0x80 completes with 0x81.
- With RESULT_PARITY_EN: op=4, a=0xA5, b=0x01 -> out_result=0xA4, out_parity=1. Op=2, a=0xA5, b=0x3C -> 0xBD, out_parity=0.
